fp_mul_param: RTL and testbench
===============================

Name: fp_mul_param

Overview:
- Parametrised IEEE-754 binary floating-point multiplier.
- Successor to the team's fixed single-precision multi-cycle multiplier. Adds:
  - configurable exponent and mantissa widths;
  - four selectable rounding modes;
  - full subnormal input/output support;
  - an inexact flag and a busy/start handshake.
- Sits in the datapath as a fixed-latency, one-operation-at-a-time arithmetic unit driven by a sequencer.

Parameters:
- EXP_W, 8: exponent field width. Bias = 2^(EXP_W-1)-1.
- MAN_W, 23: stored fraction width. Significand is MAN_W+1 bits including the hidden bit.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start_i  in  1  request new operation; accepted only when busy_o=0
- a_i  in  1+EXP_W+MAN_W  operand A, sign|exp|frac
- b_i  in  1+EXP_W+MAN_W  operand B
- rm_i  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (-inf)
- busy_o  out  1  operation in flight
- done_o  out  1  one-cycle pulse; result and flags valid
- product_o  out  1+EXP_W+MAN_W  result
- nan_o, infinit_o, overflow_o, underflow_o, inexact_o  out  1 each  status flags

Behaviour:
- Reset values: all outputs 0; FSM in IDLE. Reset mid-operation aborts it, no done_o is produced, and all outputs return to 0.
- Operand capture: a_i, b_i and rm_i are registered on the accepting edge. Later input changes do not affect the operation. start_i while busy_o=1 is ignored (no queueing).
- FSM sequence: IDLE -> UNPACK -> MULT -> NORM -> ROUND -> DONE -> IDLE.
  - busy_o=1 in every state except IDLE.
  - done_o=1 only in DONE.
  - Latency: done_o is high in the 5th cycle after the accepting edge.
  - Back-to-back: the next start_i is accepted in the IDLE cycle immediately following DONE.
- Output hold: product_o and flags are updated on entry to DONE. They hold until the next accepted start, and clear to 0 on that accepting edge.
- UNPACK:
  - Classify each operand as zero, subnormal, normal, inf or NaN.
  - Subnormals get hidden bit 0 and effective exponent 1-bias.
  - Leading-zero normalise subnormal significands, adjusting the internal exponent. The internal exponent is signed, EXP_W+3 bits wide.
- Specials, resolved in UNPACK; these skip arithmetic but still take full latency:
  - Any NaN operand, or inf*zero: product = canonical qNaN (sign 0, exp all ones, frac MSB 1, rest 0); nan_o=1.
  - inf*finite-nonzero or inf*inf: signed infinity; infinit_o=1.
  - zero*finite: signed zero (sign = XOR); no flags.
- MULT: significand product (2*MAN_W+2 bits); sign = XOR; exponent = ea+eb-bias.
- NORM:
  - If the product MSB is set, shift right 1 and exponent+1.
  - If the exponent is below the minimum normal, shift right by the deficit. Shifted-out bits OR into sticky. The shift saturates at MAN_W+3.
- ROUND:
  - Use guard, round and sticky bits per rm_i:
    - RNE: ties to even.
    - RUP: increment if inexact and positive.
    - RDN: increment if inexact and negative.
    - RTZ: truncate.
  - A rounding carry renormalises: right shift 1, exponent+1. A subnormal that carries to 1.0 becomes the minimum normal.
  - inexact_o = any guard, round or sticky bit set.
- Overflow (exponent > max finite after rounding):
  - overflow_o=1 and inexact_o=1.
  - Result is inf for RNE, for RUP when positive, and for RDN when negative; otherwise max finite.
  - infinit_o stays 0; it flags infinite operands only.
- Underflow: underflow_o=1 iff the result is tiny (below min normal, detected before rounding) AND inexact. Exact subnormal results raise no underflow.

Test Plan:
- 0x40400000 * 0x40000000, RNE, start pulsed once -> done_o exactly 5 cycles later, product 0x40C00000, all flags 0, busy_o high 5 cycles.
- 0xBFC00000 * 0x3FC00000 -> 0xC0100000. Then 0x7F800000 * 0x00000000 -> 0x7FC00000 with nan_o=1. Then 0xFF800000 * 0x40000000 -> 0xFF800000 with infinit_o=1.
- 0x7F7FFFFF * 0x40000000:
  - RNE -> 0x7F800000, overflow_o=1, inexact_o=1.
  - RTZ -> 0x7F7FFFFF, overflow_o=1.
- Subnormal:
  - 0x00800000 * 0x3F000000 -> 0x00400000, no flags.
  - 0x00800001 * 0x3F000000 RNE -> 0x00400000, underflow_o=1, inexact_o=1.
  - Same operands RUP -> 0x00400001.
- start_i held high through an operation, with a_i changed mid-flight -> result uses the captured operands, a second op starts the cycle after DONE. rst_n pulsed low in MULT -> no done_o, outputs 0, next start completes normally.
- Instance EXP_W=5, MAN_W=10:
  - 0x3C00 * 0x3C00 -> 0x3C00.
  - 0x7BFF * 0x4000 RNE -> 0x7C00 with overflow_o=1.

Source files
------------

// File: rtl/fp_mul_param.sv
// Parametrised IEEE-754 binary floating-point multiplier.
// One operation at a time, fixed five-cycle latency from the accepting edge,
// subnormal inputs/outputs, four rounding modes and IEEE-style status flags.
//
// Handshake: start_i is sampled only while busy_o=0; that edge captures
// a_i/b_i/rm_i and clears the previous result. busy_o stays high from the
// cycle after acceptance until DONE ends; done_o is a single-cycle pulse in
// DONE, and product_o plus flags then hold until the next accepted start.
module fp_mul_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [EXP_W+MAN_W:0]   a_i,
    input  logic [EXP_W+MAN_W:0]   b_i,
    input  logic [1:0]             rm_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [EXP_W+MAN_W:0]   product_o,
    output logic                   nan_o,
    output logic                   infinit_o,
    output logic                   overflow_o,
    output logic                   underflow_o,
    output logic                   inexact_o
);

    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int IE_W   = EXP_W + 3;
    localparam int BIAS   = (1 << (EXP_W - 1)) - 1;

    localparam logic signed [IE_W-1:0] BIAS_E = IE_W'(BIAS);
    localparam logic signed [IE_W-1:0] ONE_E  = IE_W'(1);
    // Biased exponent whose field would be all ones: first overflowing value.
    localparam logic signed [IE_W-1:0] EMAX_E = IE_W'((1 << EXP_W) - 1);
    // Beyond this right shift every significand bit already sits in sticky.
    localparam logic signed [IE_W-1:0] SAT_SH = IE_W'(MAN_W + 3);

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_MULT, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t state;

    // Captured operands
    logic [W-1:0] a_q, b_q;
    logic [1:0]   rm_q;

    // Unpacked operands and special-case result
    logic                   sign_q;
    logic [SIG_W-1:0]       sig_a_q, sig_b_q;
    logic signed [IE_W-1:0] exp_a_q, exp_b_q;
    logic                   special_q, spec_nan_q, spec_inf_q;
    logic [W-1:0]           spec_prod_q;

    // Product, exponent and sticky carried through MULT/NORM/ROUND
    logic [PROD_W-1:0]      prod_q;
    logic signed [IE_W-1:0] exp_q;
    logic                   sticky_q, tiny_q;

    // Normalise one operand: returns {significand with leading 1, biased exponent}.
    function automatic logic [SIG_W+IE_W-1:0] unpack_op(input logic [W-1:0] x);
        logic [EXP_W-1:0]       e;
        logic [SIG_W-1:0]       sig;
        logic signed [IE_W-1:0] ex;
        logic signed [IE_W-1:0] lz;
        logic                   found;
        e     = x[W-2:MAN_W];
        sig   = {1'b0, x[MAN_W-1:0]};
        ex    = {3'b000, e};
        lz    = '0;
        found = 1'b0;
        if (e != '0) begin
            sig[MAN_W] = 1'b1;
        end else begin
            for (int i = SIG_W - 1; i >= 0; i--) begin
                if (!found) begin
                    if (sig[i]) found = 1'b1;
                    else        lz    = lz + ONE_E;
                end
            end
            sig = sig << lz;
            ex  = ONE_E - lz;
        end
        return {sig, ex};
    endfunction

    // Operand classification and special-result selection
    logic [EXP_W-1:0] ea_f, eb_f;
    logic             a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    logic             u_sign, u_nan, u_inf, u_zero;
    logic [W-1:0]     u_spec_prod;

    // Classify both captured operands and pick the special result if any.
    always_comb begin
        ea_f   = a_q[W-2:MAN_W];
        eb_f   = b_q[W-2:MAN_W];
        a_nan  = (&ea_f) & (|a_q[MAN_W-1:0]);
        a_inf  = (&ea_f) & ~(|a_q[MAN_W-1:0]);
        a_zero = (ea_f == '0) & ~(|a_q[MAN_W-1:0]);
        b_nan  = (&eb_f) & (|b_q[MAN_W-1:0]);
        b_inf  = (&eb_f) & ~(|b_q[MAN_W-1:0]);
        b_zero = (eb_f == '0) & ~(|b_q[MAN_W-1:0]);
        u_sign = a_q[W-1] ^ b_q[W-1];
        u_nan  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
        u_inf  = ~u_nan & (a_inf | b_inf);
        u_zero = ~u_nan & ~u_inf & (a_zero | b_zero);
        if (u_nan)      u_spec_prod = QNAN;
        else if (u_inf) u_spec_prod = {u_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else            u_spec_prod = {u_sign, {(W-1){1'b0}}};
    end

    // Normalisation of the raw product
    logic [PROD_W-1:0]      n_prod, n_mask;
    logic signed [IE_W-1:0] n_exp, n_def, n_sh;
    logic                   n_sticky, n_tiny;

    // Fold a product in [2,4) down to [1,2), then denormalise tiny results.
    always_comb begin
        n_prod   = prod_q;
        n_exp    = exp_q;
        n_sticky = 1'b0;
        n_def    = '0;
        n_sh     = '0;
        n_mask   = '0;
        if (prod_q[PROD_W-1]) begin
            n_sticky = prod_q[0];
            n_prod   = prod_q >> 1;
            n_exp    = exp_q + ONE_E;
        end
        n_tiny = (n_exp < ONE_E);
        if (n_tiny) begin
            n_def    = ONE_E - n_exp;
            n_sh     = (n_def > SAT_SH) ? SAT_SH : n_def;
            n_mask   = ~({PROD_W{1'b1}} << n_sh);
            n_sticky = n_sticky | (|(n_prod & n_mask));
            n_prod   = n_prod >> n_sh;
            n_exp    = ONE_E;
        end
    end

    // Rounding and result packing
    logic [SIG_W-1:0]       r_mant;
    logic [SIG_W:0]         r_mant_inc;
    logic                   r_g, r_r, r_s, r_inexact, r_inc, r_ovf, r_to_inf;
    logic signed [IE_W-1:0] r_exp;
    logic [W-1:0]           r_prod;

    // Round the normalised significand and resolve overflow saturation.
    always_comb begin
        r_mant    = prod_q[PROD_W-2 -: SIG_W];
        r_g       = prod_q[SIG_W-2];
        r_r       = prod_q[SIG_W-3];
        r_s       = sticky_q | (|prod_q[SIG_W-4:0]);
        r_inexact = r_g | r_r | r_s;
        case (rm_q)
            2'b00:   r_inc = r_g & (r_r | r_s | r_mant[0]);
            2'b10:   r_inc = r_inexact & ~sign_q;
            2'b11:   r_inc = r_inexact & sign_q;
            default: r_inc = 1'b0;
        endcase
        r_mant_inc = {1'b0, r_mant} + {{SIG_W{1'b0}}, r_inc};
        r_exp      = exp_q;
        if (r_mant_inc[SIG_W]) begin
            r_mant_inc = r_mant_inc >> 1;
            r_exp      = exp_q + ONE_E;
        end
        r_ovf    = (r_exp >= EMAX_E);
        r_to_inf = (rm_q == 2'b00) | ((rm_q == 2'b10) & ~sign_q) | ((rm_q == 2'b11) & sign_q);
        if (r_ovf && r_to_inf)
            r_prod = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (r_ovf)
            r_prod = {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        else
            // A clear hidden bit means subnormal or zero: exponent field 0.
            r_prod = {sign_q, r_mant_inc[MAN_W] ? r_exp[EXP_W-1:0] : {EXP_W{1'b0}},
                      r_mant_inc[MAN_W-1:0]};
    end

    // Datapath pipeline registers, advanced one step per FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            rm_q        <= '0;
            sign_q      <= 1'b0;
            sig_a_q     <= '0;
            sig_b_q     <= '0;
            exp_a_q     <= '0;
            exp_b_q     <= '0;
            special_q   <= 1'b0;
            spec_nan_q  <= 1'b0;
            spec_inf_q  <= 1'b0;
            spec_prod_q <= '0;
            prod_q      <= '0;
            exp_q       <= '0;
            sticky_q    <= 1'b0;
            tiny_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        a_q  <= a_i;
                        b_q  <= b_i;
                        rm_q <= rm_i;
                    end
                end
                S_UNPACK: begin
                    sign_q               <= u_sign;
                    {sig_a_q, exp_a_q}   <= unpack_op(a_q);
                    {sig_b_q, exp_b_q}   <= unpack_op(b_q);
                    special_q            <= u_nan | u_inf | u_zero;
                    spec_nan_q           <= u_nan;
                    spec_inf_q           <= u_inf;
                    spec_prod_q          <= u_spec_prod;
                end
                S_MULT: begin
                    prod_q <= {{SIG_W{1'b0}}, sig_a_q} * {{SIG_W{1'b0}}, sig_b_q};
                    exp_q  <= exp_a_q + exp_b_q - BIAS_E;
                end
                S_NORM: begin
                    prod_q   <= n_prod;
                    exp_q    <= n_exp;
                    sticky_q <= n_sticky;
                    tiny_q   <= n_tiny;
                end
                default: ;
            endcase
        end
    end

    // Control FSM with registered busy/done and result/flag outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            product_o   <= '0;
            nan_o       <= 1'b0;
            infinit_o   <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            inexact_o   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state       <= S_UNPACK;
                        busy_o      <= 1'b1;
                        product_o   <= '0;
                        nan_o       <= 1'b0;
                        infinit_o   <= 1'b0;
                        overflow_o  <= 1'b0;
                        underflow_o <= 1'b0;
                        inexact_o   <= 1'b0;
                    end
                end
                S_UNPACK: state <= S_MULT;
                S_MULT:   state <= S_NORM;
                S_NORM:   state <= S_ROUND;
                S_ROUND: begin
                    state  <= S_DONE;
                    done_o <= 1'b1;
                    if (special_q) begin
                        product_o   <= spec_prod_q;
                        nan_o       <= spec_nan_q;
                        infinit_o   <= spec_inf_q;
                        overflow_o  <= 1'b0;
                        underflow_o <= 1'b0;
                        inexact_o   <= 1'b0;
                    end else begin
                        product_o   <= r_prod;
                        nan_o       <= 1'b0;
                        infinit_o   <= 1'b0;
                        overflow_o  <= r_ovf;
                        underflow_o <= tiny_q & r_inexact & ~r_ovf;
                        inexact_o   <= r_inexact | r_ovf;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_param.sv
// Directed bench for fp_mul_param: a single-precision and a half-precision
// instance share one clock; expected results go into a queue when an
// operation is launched and are popped when done_o is seen.
module tb_fp_mul_param;

    localparam int W = 37;  // 32-bit product slot + 5 flag bits

    logic clk;
    logic rst_n;

    logic        start32, busy32, done32;
    logic [31:0] a32, b32, p32;
    logic [1:0]  rm32;
    logic        nan32, inf32, ovf32, unf32, inx32;

    logic        start16, busy16, done16;
    logic [15:0] a16, b16, p16;
    logic [1:0]  rm16;
    logic        nan16, inf16, ovf16, unf16, inx16;

    logic [W-1:0] exp_q[$];
    int n_tests;
    int n_fail;

    fp_mul_param #(.EXP_W(8), .MAN_W(23)) dut32 (
        .clk(clk), .rst_n(rst_n), .start_i(start32), .a_i(a32), .b_i(b32), .rm_i(rm32),
        .busy_o(busy32), .done_o(done32), .product_o(p32),
        .nan_o(nan32), .infinit_o(inf32), .overflow_o(ovf32),
        .underflow_o(unf32), .inexact_o(inx32)
    );

    fp_mul_param #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk(clk), .rst_n(rst_n), .start_i(start16), .a_i(a16), .b_i(b16), .rm_i(rm16),
        .busy_o(busy16), .done_o(done16), .product_o(p16),
        .nan_o(nan16), .infinit_o(inf16), .overflow_o(ovf16),
        .underflow_o(unf16), .inexact_o(inx16)
    );

    // clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // flag packing: {nan, inf, ovf, unf, inx}
    function automatic logic [W-1:0] e32(input logic [31:0] p, input logic [4:0] f);
        return {p, f};
    endfunction

    function automatic logic [W-1:0] e16(input logic [15:0] p, input logic [4:0] f);
        return {16'h0000, p, f};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called #1 after the accepting edge; follows the op until done_o.
    task automatic wait_done(input bit sel, input string tag);
        int cyc;
        int busy_cnt;
        logic dn;
        logic [W-1:0] e;
        logic [W-1:0] obs;
        cyc = 1;
        dn = sel ? done16 : done32;
        busy_cnt = int'(sel ? busy16 : busy32);
        while (!dn && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            dn = sel ? done16 : done32;
            busy_cnt += int'(sel ? busy16 : busy32);
        end
        check({tag, "_latency"}, 64'(cyc), 64'd5);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd5);
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        if (dn) begin
            obs = sel ? {16'h0000, p16, nan16, inf16, ovf16, unf16, inx16}
                      : {p32, nan32, inf32, ovf32, unf32, inx32};
            check({tag, "_result"}, 64'(obs), 64'(e));
        end
    endtask

    task automatic run_op(input bit sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] rm, input logic [W-1:0] e, input string tag);
        exp_q.push_back(e);
        if (sel) begin
            a16 = a[15:0]; b16 = b[15:0]; rm16 = rm; start16 = 1'b1;
        end else begin
            a32 = a; b32 = b; rm32 = rm; start32 = 1'b1;
        end
        @(posedge clk); #1;
        start16 = 1'b0;
        start32 = 1'b0;
        wait_done(sel, tag);
        @(posedge clk); #1;
    endtask

    initial begin
        int seen_done;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        start32 = 1'b0; a32 = '0; b32 = '0; rm32 = '0;
        start16 = 1'b0; a16 = '0; b16 = '0; rm16 = '0;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy32), 64'd0);
        check("rst_done", 64'(done32), 64'd0);
        check("rst_out32", 64'({p32, nan32, inf32, ovf32, unf32, inx32}), 64'd0);
        check("rst_out16", 64'({busy16, done16, p16, nan16, inf16, ovf16, unf16, inx16}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic normal products and specials
        run_op(0, 32'h40400000, 32'h40000000, 2'b00, e32(32'h40C00000, 5'b00000), "mul_3x2");
        repeat (3) @(posedge clk);
        #1;
        check("hold_result", 64'({p32, nan32, inf32, ovf32, unf32, inx32}),
              64'(e32(32'h40C00000, 5'b00000)));
        check("hold_done_low", 64'(done32), 64'd0);
        run_op(0, 32'hBFC00000, 32'h3FC00000, 2'b00, e32(32'hC0100000, 5'b00000), "mul_neg");
        run_op(0, 32'h7F800000, 32'h00000000, 2'b00, e32(32'h7FC00000, 5'b10000), "inf_x_zero");
        run_op(0, 32'hFF800000, 32'h40000000, 2'b00, e32(32'hFF800000, 5'b01000), "ninf_x_2");
        run_op(0, 32'h80000000, 32'h40000000, 2'b00, e32(32'h80000000, 5'b00000), "nzero_x_2");
        run_op(0, 32'h7FC00001, 32'h3F800000, 2'b01, e32(32'h7FC00000, 5'b10000), "nan_in");

        // overflow in each rounding direction
        run_op(0, 32'h7F7FFFFF, 32'h40000000, 2'b00, e32(32'h7F800000, 5'b00101), "ovf_rne");
        run_op(0, 32'h7F7FFFFF, 32'h40000000, 2'b01, e32(32'h7F7FFFFF, 5'b00101), "ovf_rtz");
        run_op(0, 32'hFF7FFFFF, 32'h40000000, 2'b10, e32(32'hFF7FFFFF, 5'b00101), "ovf_rup_neg");
        run_op(0, 32'hFF7FFFFF, 32'h40000000, 2'b11, e32(32'hFF800000, 5'b00101), "ovf_rdn_neg");

        // rounding of normal results
        run_op(0, 32'h3F800001, 32'h3F800001, 2'b00, e32(32'h3F800002, 5'b00001), "rnd_rne");
        run_op(0, 32'h3F800001, 32'h3F800001, 2'b10, e32(32'h3F800003, 5'b00001), "rnd_rup");

        // subnormal results and inputs
        run_op(0, 32'h00800000, 32'h3F000000, 2'b00, e32(32'h00400000, 5'b00000), "sub_exact");
        run_op(0, 32'h00800001, 32'h3F000000, 2'b00, e32(32'h00400000, 5'b00011), "sub_rne_tie");
        run_op(0, 32'h00800001, 32'h3F000000, 2'b10, e32(32'h00400001, 5'b00011), "sub_rup");
        run_op(0, 32'h00800001, 32'h3F000000, 2'b11, e32(32'h00400000, 5'b00011), "sub_rdn_pos");
        run_op(0, 32'h80800001, 32'h3F000000, 2'b11, e32(32'h80400001, 5'b00011), "sub_rdn_neg");
        run_op(0, 32'h00000001, 32'h4B000000, 2'b00, e32(32'h00800000, 5'b00000), "sub_in_norm");
        run_op(0, 32'h007FFFFF, 32'h3F800001, 2'b00, e32(32'h00800000, 5'b00011), "sub_carry_min");
        run_op(0, 32'h007FFFFF, 32'h3F800001, 2'b01, e32(32'h007FFFFF, 5'b00011), "sub_rtz");

        // start held high, operand changed mid-flight, back-to-back accept
        exp_q.push_back(e32(32'h40C00000, 5'b00000));
        exp_q.push_back(e32(32'h40000000, 5'b00000));
        a32 = 32'h40400000; b32 = 32'h40000000; rm32 = 2'b00; start32 = 1'b1;
        @(posedge clk); #1;
        a32 = 32'h3F800000;
        wait_done(0, "hold_start_1");
        @(posedge clk); #1;
        check("b2b_idle_busy", 64'(busy32), 64'd0);
        @(posedge clk); #1;
        start32 = 1'b0;
        wait_done(0, "hold_start_2");
        @(posedge clk); #1;

        // reset during MULT aborts the operation
        a32 = 32'h40400000; b32 = 32'h40000000; rm32 = 2'b00; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check("abort_busy", 64'(busy32), 64'd0);
        check("abort_out", 64'({done32, p32, nan32, inf32, ovf32, unf32, inx32}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done32) seen_done++;
        end
        check("abort_no_done", 64'(seen_done), 64'd0);
        run_op(0, 32'h40400000, 32'h40000000, 2'b00, e32(32'h40C00000, 5'b00000), "after_abort");

        // half-precision instance
        run_op(1, 32'h3C00, 32'h3C00, 2'b00, e16(16'h3C00, 5'b00000), "h_one");
        run_op(1, 32'h7BFF, 32'h4000, 2'b00, e16(16'h7C00, 5'b00101), "h_ovf_rne");
        run_op(1, 32'h7BFF, 32'h4000, 2'b01, e16(16'h7BFF, 5'b00101), "h_ovf_rtz");
        run_op(1, 32'h0001, 32'h3C00, 2'b00, e16(16'h0001, 5'b00000), "h_sub_exact");

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
